seven_segment_chain_driver: RTL and testbench
=============================================

Name: seven_segment_chain_driver

Overview:
Serial transmitter for the seven-segment daisy chain. It consumes 32-bit display command words from the bus-side register: D[7:0] is the data block, D[15:8] the display type, D[23:16] the target display index. It keeps a shadow pattern per display and, after every accepted command, shifts the full chain out on a clock/data/latch interface (shift-register style, 8 bits per display).

Parameters:
NUM_DISPLAYS, 4, number of displays in the chain (1..255)
CLK_DIV, 4, clock cycles per ser_clk half-period (>=1)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd  in  32  command word: [7:0] data, [15:8] display type, [23:16] display index, [31:24] reserved/ignored
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
ser_clk  out  1  chain shift clock; data is sampled by the chain on its rising edge
ser_data  out  1  chain serial data
ser_latch  out  1  chain latch strobe
done  out  1  one-cycle pulse when a chain update completes
err  out  1  one-cycle pulse when a command with index >= NUM_DISPLAYS is dropped

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - All shadow patterns 0x00.
  - State IDLE.
  - ser_clk, ser_data, ser_latch, done and err are 0.
  - cmd_ready is 1 in the first cycle after reset is released.
- Handshake:
  - A command is accepted in a cycle with cmd_valid & cmd_ready.
  - cmd_ready is 1 only in IDLE.
  - cmd is sampled only on accept. The master must hold cmd stable while cmd_valid=1 and cmd_ready=0.
- Display type:
  - 0x00: raw pattern, bit0=a … bit6=g, bit7=dp.
  - 0x01: hex decode; see Optional Feature.
  - Any other value: treated as raw.
- Bad index: a command with index >= NUM_DISPLAYS is accepted and dropped.
  - No shadow update and no shift.
  - err pulses in the cycle after accept; cmd_ready stays 1.
- States: IDLE -> LOAD -> SHIFT -> LATCH -> IDLE.
  - LOAD (1 cycle, cycle after accept):
    - Shadow[index] is written.
    - Shift register is loaded with all shadows, display NUM_DISPLAYS-1 in the MSBs.
    - Bit counter is set to 8*NUM_DISPLAYS.
  - SHIFT, per bit:
    - ser_data is set to the shift-register MSB with ser_clk=0 for CLK_DIV cycles.
    - Then ser_clk=1 for CLK_DIV cycles, with ser_data held.
    - Then shift left and decrement the counter. Order is farthest display first, dp bit first within each display.
    - Leave SHIFT after the last bit's high phase.
  - LATCH: ser_clk=0, ser_latch=1 for CLK_DIV cycles.
  - Return to IDLE: done=1 for exactly that first IDLE cycle; cmd_ready=1 in the same cycle.
- Latency: accept at cycle 0 -> cmd_ready high again at cycle 2 + 16*NUM_DISPLAYS*CLK_DIV + CLK_DIV.
- Back-to-back: cmd_valid held through the done cycle is accepted in that cycle.
- Reset mid-operation: abort immediately.
  - No latch pulse; outputs 0.
  - Shadows cleared; the displays keep their previously latched content.
- Counter widths are sized from 8*NUM_DISPLAYS and CLK_DIV. No wrap-around is possible within legal parameters.

Optional Feature:
- Macro: SEVEN_SEGMENT_HEX_DECODE_EN.
- Defined: type 0x01 decodes data[3:0] to segments and takes dp from data[4]. Table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
- Undefined: type 0x01 is treated as raw; no decode logic is present.

Test Plan:
1. Reset, then idle 10 cycles -> cmd_ready=1, serial outputs 0, done=0, err=0.
2. NUM_DISPLAYS=2, CLK_DIV=2. Accept cmd=0x0000_0006 at cycle 0 -> 16 ser_clk rising edges. Bits sampled: 0x00 then 0x06, MSB first. ser_latch high cycles 66-67, done and cmd_ready high at cycle 68.
3. Same config, cmd=0x0001_0100 with macro defined -> shadow[1]=0x3F. Stream is 0x3F,0x06 (display 0 keeps its earlier value). Without the macro the stream is 0x00,0x06.
4. cmd=0x0005_0000 with NUM_DISPLAYS=2 -> err pulse at cycle 1, no ser_clk activity, cmd_ready stays 1.
5. cmd_valid held high with a second command during a shift -> cmd_ready=0 until the done cycle; the second command is accepted in the done cycle and a new LOAD follows.
6. Assert reset at cycle 20 of a shift -> next cycle all outputs 0, no ser_latch pulse, cmd_ready=1 after release.

Source files
------------

// File: rtl/seven_segment_chain_driver.sv
// -----------------------------------------------------------------------------
// seven_segment_chain_driver
//
// Serial transmitter for a daisy chain of seven-segment displays. Each accepted
// 32-bit command updates one display's shadow pattern. The whole chain is then
// shifted out on a clock/data/latch interface, 8 bits per display, and latched.
//
// Optional feature macro: SEVEN_SEGMENT_HEX_DECODE_EN
//   defined   : display type 0x01 decodes data[3:0] to segments, dp from data[4]
//   undefined : type 0x01 is treated as a raw pattern (no decode logic present)
//
// Parameters:
//   NUM_DISPLAYS - displays in the chain (1..255)
//   CLK_DIV      - system clocks per ser_clk half-period (>=1)
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   cmd[31:0]  in   [7:0] data, [15:8] display type, [23:16] index, [31:24] ignored
//   cmd_valid  in   command present
//   cmd_ready  out  high only in IDLE
//   ser_clk    out  chain shift clock (chain samples on rising edge)
//   ser_data   out  chain serial data
//   ser_latch  out  chain latch strobe
//   done       out  one-cycle pulse when a chain update completes
//   err        out  one-cycle pulse when an out-of-range index is dropped
// -----------------------------------------------------------------------------
module seven_segment_chain_driver #(
  parameter int NUM_DISPLAYS = 4,
  parameter int CLK_DIV      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cmd,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        ser_clk,
  output logic        ser_data,
  output logic        ser_latch,
  output logic        done,
  output logic        err
);

  localparam int CHAIN_W = 8 * NUM_DISPLAYS;
  localparam int CNT_W   = $clog2(CHAIN_W + 1);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CHAIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [8:0]       IDX_LIMIT = 9'(NUM_DISPLAYS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_LATCH = 2'd3
  } state_t;

`ifdef SEVEN_SEGMENT_HEX_DECODE_EN
  // Hex digit to segments a..g (bit0 = a).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction
`endif

  state_t             r_state, w_state_next;
  logic [7:0]         r_shadow [NUM_DISPLAYS];
  logic [7:0]         w_shadow_next [NUM_DISPLAYS];
  logic [CHAIN_W-1:0] r_shift, w_shift_next, w_chain;
  logic [CNT_W-1:0]   r_bits, w_bits_next;
  logic [DIV_W-1:0]   r_div, w_div_next;
  logic               r_phase, w_phase_next;   // 0: ser_clk low half, 1: high half
  logic [7:0]         r_idx, w_idx_next;
  logic [7:0]         r_data, w_data_next;
  logic [7:0]         w_pattern;
  logic               r_ready, r_ser_clk, r_ser_data, r_ser_latch, r_done, r_err;
  logic               w_ser_clk_next, w_ser_data_next, w_ser_latch_next;
  logic               w_done_next, w_err_next;
  logic               w_unused_bits;

`ifdef SEVEN_SEGMENT_HEX_DECODE_EN
  logic r_hex, w_hex_next;

  assign w_unused_bits = ^cmd[31:24];

  // Pattern to store: decoded hex digit or the raw byte.
  always_comb begin
    if (r_hex) begin
      w_pattern = {r_data[4], hex_to_seg(r_data[3:0])};
    end else begin
      w_pattern = r_data;
    end
  end
`else
  // Without decode every display type is raw, so the type byte is not needed.
  assign w_unused_bits = ^{cmd[31:24], cmd[15:8]};
  assign w_pattern     = r_data;
`endif

  assign cmd_ready = r_ready;
  assign ser_clk   = r_ser_clk;
  assign ser_data  = r_ser_data;
  assign ser_latch = r_ser_latch;
  assign done      = r_done;
  assign err       = r_err;

  // State, datapath and registered outputs; reset aborts any update in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < NUM_DISPLAYS; i++) begin
        r_shadow[i] <= 8'h00;
      end
      r_shift     <= '0;
      r_bits      <= '0;
      r_div       <= '0;
      r_phase     <= 1'b0;
      r_idx       <= 8'h00;
      r_data      <= 8'h00;
`ifdef SEVEN_SEGMENT_HEX_DECODE_EN
      r_hex       <= 1'b0;
`endif
      r_ready     <= 1'b1;
      r_ser_clk   <= 1'b0;
      r_ser_data  <= 1'b0;
      r_ser_latch <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shadow    <= w_shadow_next;
      r_shift     <= w_shift_next;
      r_bits      <= w_bits_next;
      r_div       <= w_div_next;
      r_phase     <= w_phase_next;
      r_idx       <= w_idx_next;
      r_data      <= w_data_next;
`ifdef SEVEN_SEGMENT_HEX_DECODE_EN
      r_hex       <= w_hex_next;
`endif
      r_ready     <= (w_state_next == S_IDLE);
      r_ser_clk   <= w_ser_clk_next;
      r_ser_data  <= w_ser_data_next;
      r_ser_latch <= w_ser_latch_next;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
    end
  end

  // Next-state, datapath updates and next output values.
  always_comb begin
    w_state_next     = r_state;
    w_shadow_next    = r_shadow;
    w_shift_next     = r_shift;
    w_chain          = '0;
    w_bits_next      = r_bits;
    w_div_next       = r_div;
    w_phase_next     = r_phase;
    w_idx_next       = r_idx;
    w_data_next      = r_data;
`ifdef SEVEN_SEGMENT_HEX_DECODE_EN
    w_hex_next       = r_hex;
`endif
    w_ser_clk_next   = r_ser_clk;
    w_ser_data_next  = r_ser_data;
    w_ser_latch_next = 1'b0;
    w_done_next      = 1'b0;
    w_err_next       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if ({1'b0, cmd[23:16]} < IDX_LIMIT) begin
            w_idx_next   = cmd[23:16];
            w_data_next  = cmd[7:0];
`ifdef SEVEN_SEGMENT_HEX_DECODE_EN
            w_hex_next   = (cmd[15:8] == 8'h01);
`endif
            w_state_next = S_LOAD;
          end else begin
            // Out-of-range index: consumed and dropped, stay in IDLE.
            w_err_next   = 1'b1;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end

      S_LOAD: begin
        for (int i = 0; i < NUM_DISPLAYS; i++) begin
          if (r_idx == 8'(i)) begin
            w_shadow_next[i] = w_pattern;
          end else begin
            w_shadow_next[i] = r_shadow[i];
          end
        end
        // Farthest display (NUM_DISPLAYS-1) sits in the MSBs so it leaves first.
        for (int i = 0; i < NUM_DISPLAYS; i++) begin
          w_chain[8*i +: 8] = w_shadow_next[i];
        end
        w_shift_next    = w_chain;
        w_bits_next     = CNT_FULL;
        w_div_next      = '0;
        w_phase_next    = 1'b0;
        w_ser_clk_next  = 1'b0;
        w_ser_data_next = w_chain[CHAIN_W-1];
        w_state_next    = S_SHIFT;
      end

      S_SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_div_next = '0;
          if (!r_phase) begin
            w_phase_next   = 1'b1;
            w_ser_clk_next = 1'b1;
          end else begin
            // End of the high half: advance to the next bit.
            w_phase_next   = 1'b0;
            w_ser_clk_next = 1'b0;
            w_shift_next   = r_shift << 1;
            w_bits_next    = r_bits - CNT_ONE;
            if (r_bits == CNT_ONE) begin
              w_ser_data_next  = 1'b0;
              w_ser_latch_next = 1'b1;
              w_state_next     = S_LATCH;
            end else begin
              w_ser_data_next  = r_shift[CHAIN_W-2];
            end
          end
        end else begin
          w_div_next = r_div + DIV_ONE;
        end
      end

      S_LATCH: begin
        w_ser_clk_next = 1'b0;
        if (r_div == DIV_LAST) begin
          w_div_next       = '0;
          w_ser_latch_next = 1'b0;
          w_done_next      = 1'b1;
          w_state_next     = S_IDLE;
        end else begin
          w_div_next       = r_div + DIV_ONE;
          w_ser_latch_next = 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seven_segment_chain_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_chain_driver
//
// Self-checking bench for seven_segment_chain_driver (NUM_DISPLAYS=2,
// CLK_DIV=2). A reference model keeps the shadow patterns as a plain array and
// predicts the serial stream and event timing from the command rules.
// Honours SEVEN_SEGMENT_HEX_DECODE_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_seven_segment_chain_driver;

  localparam int N       = 2;
  localparam int D       = 2;
  localparam int CHAIN_W = 8 * N;
  localparam int DONE_AT = 2 + 16 * N * D + D;

`ifdef SEVEN_SEGMENT_HEX_DECODE_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cmd = 32'h0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready, ser_clk, ser_data, ser_latch, done, err;

  int checks = 0;
  int errors = 0;

  logic [7:0] sh [N];

  seven_segment_chain_driver #(.NUM_DISPLAYS(N), .CLK_DIV(D)) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .ser_clk  (ser_clk),
    .ser_data (ser_data),
    .ser_latch(ser_latch),
    .done     (done),
    .err      (err)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] model_pattern(input logic [31:0] c);
    logic [7:0] d;
    d = c[7:0];
    if (HEX_EN && c[15:8] == 8'h01) return {d[4], SEG[d[3:0]]};
    return d;
  endfunction

  task automatic accept_cmd(input logic [31:0] c);
    @(negedge clock);
    cmd = c;
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: got %b want 1", cmd_ready);
    end
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  // Watches one command from cycle 1 after accept and checks it against the model.
  task automatic observe(input logic [31:0] c, input bit inject, input logic [31:0] c2);
    logic [CHAIN_W-1:0] exp_chain, got;
    int idx, rises, first_rise, latch_first, latch_last, latch_cnt;
    int done_cyc, ready_bad, err_cnt, err_first, stray_done, limit;
    bit prev_clk, good, done_ready;
    idx = int'(c[23:16]);
    good = (idx < N);
    if (good) sh[idx] = model_pattern(c);
    for (int i = 0; i < N; i++) exp_chain[8*i +: 8] = sh[i];
    got = '0; rises = 0; first_rise = -1; latch_first = -1; latch_last = -1; latch_cnt = 0;
    done_cyc = -1; ready_bad = 0; err_cnt = 0; err_first = -1; stray_done = 0;
    prev_clk = 1'b0; done_ready = 1'b0;
    limit = good ? 300 : 10;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clock);
      if (inject && k == 20) begin
        cmd = c2;
        cmd_valid = 1'b1;
      end
      if (ser_clk && !prev_clk) begin
        rises++;
        if (first_rise < 0) first_rise = k;
        got = {got[CHAIN_W-2:0], ser_data};
      end
      prev_clk = ser_clk;
      if (ser_latch) begin
        latch_cnt++;
        if (latch_first < 0) latch_first = k;
        latch_last = k;
      end
      if (err) begin
        err_cnt++;
        if (err_first < 0) err_first = k;
      end
      if (good && done) begin
        done_cyc = k;
        done_ready = cmd_ready;
        break;
      end
      if (!good && done) stray_done++;
      if (good && cmd_ready) ready_bad++;
      if (!good && !cmd_ready) ready_bad++;
    end
    if (good) begin
      checks++; if (rises != CHAIN_W) begin errors++; $display("FAIL rise_count cmd=%h: got %0d want %0d", c, rises, CHAIN_W); end
      checks++; if (got !== exp_chain) begin errors++; $display("FAIL stream cmd=%h: got %h want %h", c, got, exp_chain); end
      checks++; if (first_rise != 2 + D) begin errors++; $display("FAIL first_rise cmd=%h: got %0d want %0d", c, first_rise, 2 + D); end
      checks++; if (latch_first != DONE_AT - D || latch_last != DONE_AT - 1 || latch_cnt != D) begin
        errors++; $display("FAIL latch cmd=%h: got %0d..%0d (%0d) want %0d..%0d", c, latch_first, latch_last, latch_cnt, DONE_AT - D, DONE_AT - 1);
      end
      checks++; if (done_cyc != DONE_AT) begin errors++; $display("FAIL done_cycle cmd=%h: got %0d want %0d", c, done_cyc, DONE_AT); end
      checks++; if (done_ready !== 1'b1) begin errors++; $display("FAIL done_ready cmd=%h: got %b want 1", c, done_ready); end
      checks++; if (ready_bad != 0) begin errors++; $display("FAIL busy_ready cmd=%h: got %0d ready cycles want 0", c, ready_bad); end
      checks++; if (err_cnt != 0) begin errors++; $display("FAIL no_err cmd=%h: got %0d pulses want 0", c, err_cnt); end
    end else begin
      checks++; if (err_cnt != 1 || err_first != 1) begin errors++; $display("FAIL err_pulse cmd=%h: got %0d pulses first %0d want 1 at 1", c, err_cnt, err_first); end
      checks++; if (rises != 0 || latch_cnt != 0 || stray_done != 0) begin
        errors++; $display("FAIL bad_idx_quiet cmd=%h: got rises %0d latch %0d done %0d want 0", c, rises, latch_cnt, stray_done);
      end
      checks++; if (ready_bad != 0) begin errors++; $display("FAIL bad_idx_ready cmd=%h: got %0d low cycles want 0", c, ready_bad); end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < N; i++) sh[i] = 8'h00;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_first: got %b want 1", cmd_ready); end
    repeat (10) @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    checks++;
    if ({ser_clk, ser_data, ser_latch, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000", {ser_clk, ser_data, ser_latch, done, err});
    end
  endtask

  task automatic test_directed;
    accept_cmd(32'h0000_0006);
    observe(32'h0000_0006, 1'b0, 32'h0);
    accept_cmd(32'h0001_0100);
    observe(32'h0001_0100, 1'b0, 32'h0);
  endtask

  task automatic test_bad_index;
    accept_cmd(32'h0005_0000);
    observe(32'h0005_0000, 1'b0, 32'h0);
  endtask

  task automatic test_random;
    logic [31:0] c;
    for (int n = 0; n < 10; n++) begin
      c = $urandom;
      c[23:16] = 8'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       c[15:8] = 8'h00;
        1:       c[15:8] = 8'h01;
        default: c[15:8] = 8'($urandom);
      endcase
      accept_cmd(c);
      observe(c, 1'b0, 32'h0);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    a = {8'h00, 8'h00, 8'h00, 8'($urandom)};
    b = {8'h00, 8'h01, 8'h01, 8'($urandom)};
    accept_cmd(a);
    observe(a, 1'b1, b);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    observe(b, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid;
    int latch_seen;
    logic [31:0] c;
    latch_seen = 0;
    accept_cmd(32'h0001_00FF);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({ser_clk, ser_data, ser_latch, done, err} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got %b want 00000", {ser_clk, ser_data, ser_latch, done, err});
    end
    for (int i = 0; i < N; i++) sh[i] = 8'h00;
    repeat (2) begin
      @(negedge clock);
      if (ser_latch) latch_seen++;
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", cmd_ready); end
    repeat (10) begin
      @(negedge clock);
      if (ser_latch) latch_seen++;
    end
    checks++;
    if (latch_seen != 0) begin errors++; $display("FAIL mid_reset_latch: got %0d pulses want 0", latch_seen); end
    c = {8'h00, 8'h00, 8'h00, 8'($urandom)};
    accept_cmd(c);
    observe(c, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bad_index();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
